// File: rtl/i2c_arb_pkg.sv
// Shared encodings and field widths for the I2C transaction arbiter.
package i2c_arb_pkg;

    localparam int CHIP_ADDR_W = 7;
    localparam int REG_W       = 8;
    localparam int STATUS_W    = 3;

    // Status reported to the requester when the master never answered.
    localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } arb_state_e;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant plus its index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the requester after last_i, wrapping, and take the first pending one.
    always_comb begin
        int   pos;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last_i) + k) % N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master among NUM_REQ requesters: round-robin grant, one
// byte transaction per grant, watchdog in the wait phase, inter-txn gap.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TXN_GAP     = 0,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [CHIP_ADDR_W*NUM_REQ-1:0] req_chip_addr,
    input  logic [REG_W*NUM_REQ-1:0]       req_reg_addr,
    input  logic [REG_W*NUM_REQ-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [REG_W-1:0]               rsp_data,
    output logic [STATUS_W-1:0]            rsp_status,
    output logic [CHIP_ADDR_W-1:0]         m_chip_addr,
    output logic [REG_W-1:0]               m_reg_addr,
    output logic [REG_W-1:0]               m_data_in,
    output logic                           m_write_en,
    output logic                           m_read_en,
    input  logic                           m_done,
    input  logic                           m_busy,
    input  logic [STATUS_W-1:0]            m_status,
    input  logic [REG_W-1:0]               m_data_out
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > TXN_GAP) ? TIMEOUT_CYC : TXN_GAP;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   read_q, read_d;
    logic [CHIP_ADDR_W-1:0] chip_q, chip_d;
    logic [REG_W-1:0]       reg_q, reg_d;
    logic [REG_W-1:0]       wdata_q, wdata_d;
    logic                   wen_q, wen_d;
    logic                   ren_q, ren_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [REG_W-1:0]       rsp_data_q, rsp_data_d;
    logic [STATUS_W-1:0]    rsp_status_q, rsp_status_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]     ack_d;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // Next-state and output decode; counter doubles as watchdog and gap timer.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        idx_d        = idx_q;
        read_d       = read_q;
        chip_d       = chip_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        wen_d        = 1'b0;
        ren_d        = 1'b0;
        done_d       = '0;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid && !m_busy) begin
                    ack_d   = gnt;
                    last_d  = gnt_idx;
                    idx_d   = gnt_idx;
                    read_d  = req_read[gnt_idx];
                    chip_d  = req_chip_addr[int'(gnt_idx)*CHIP_ADDR_W +: CHIP_ADDR_W];
                    reg_d   = req_reg_addr[int'(gnt_idx)*REG_W +: REG_W];
                    wdata_d = req_wdata[int'(gnt_idx)*REG_W +: REG_W];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wen_d   = !read_q;
                ren_d   = read_q;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    done_d[idx_q] = 1'b1;
                    rsp_data_d    = m_data_out;
                    rsp_status_d  = m_status;
                    cnt_d         = '0;
                    state_d       = S_GAP;
                end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    done_d[idx_q] = 1'b1;
                    rsp_data_d    = '0;
                    rsp_status_d  = STATUS_TIMEOUT;
                    cnt_d         = '0;
                    state_d       = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (TXN_GAP <= 1 || cnt_q == CNT_W'(TXN_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; a reset drops any transaction silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_q       <= IDX_W'(NUM_REQ - 1);
            idx_q        <= '0;
            read_q       <= 1'b0;
            chip_q       <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            done_q       <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            read_q       <= read_d;
            chip_q       <= chip_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            ren_q        <= ren_d;
            done_q       <= done_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            cnt_q        <= cnt_d;
        end
    end

    // Ack is combinational so the requester knows its fields were taken this cycle.
    assign req_ack     = ack_d & {NUM_REQ{reset}};
    assign req_done    = done_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign m_chip_addr = chip_q;
    assign m_reg_addr  = reg_q;
    assign m_data_in   = wdata_q;
    assign m_write_en  = wen_q;
    assign m_read_en   = ren_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: behavioural master model, table of single
// transactions with a response scoreboard, then contention/timeout/reset cases.
module tb_i2c_txn_arbiter;

    localparam int N   = 2;
    localparam int GAP = 10;
    localparam int TO  = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_read, req_ack, req_done;
    logic [7*N-1:0] req_chip_addr;
    logic [8*N-1:0] req_reg_addr, req_wdata;
    logic [7:0]    rsp_data, m_reg_addr, m_data_in, m_data_out;
    logic [2:0]    rsp_status, m_status;
    logic [6:0]    m_chip_addr;
    logic          m_write_en, m_read_en, m_done, m_busy;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.NUM_REQ(N), .TXN_GAP(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_read(req_read), .req_chip_addr(req_chip_addr),
        .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_done(req_done), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
        .m_write_en(m_write_en), .m_read_en(m_read_en),
        .m_done(m_done), .m_busy(m_busy), .m_status(m_status), .m_data_out(m_data_out)
    );

    // Master model: after an enable pulse, answer model_lat cycles later.
    logic       model_hang = 1'b0;
    int         model_lat  = 4;
    logic [7:0] model_rdata = 8'h00;
    logic [2:0] model_status = 3'b000;
    int         mcnt;
    logic       mact;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done <= 1'b0; m_busy <= 1'b0; mact <= 1'b0; mcnt <= 0;
            m_status <= 3'b000; m_data_out <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (!mact && (m_write_en || m_read_en) && !model_hang) begin
                mact <= 1'b1; m_busy <= 1'b1; mcnt <= model_lat;
            end else if (mact) begin
                if (mcnt <= 1) begin
                    mact <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
                    m_status <= model_status; m_data_out <= model_rdata;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    typedef struct {
        int         idx;
        logic       rd;
        logic [6:0] chip;
        logic [7:0] ra;
        logic [7:0] wd;
        logic [7:0] mdata;
        logic [2:0] mstat;
        logic [1:0] exp_done;
        logic [7:0] exp_data;
        logic [2:0] exp_stat;
    } vec_t;

    typedef struct { logic rd; logic [6:0] chip; logic [7:0] ra; logic [7:0] wd; } cmd_t;
    typedef struct { logic [1:0] done; logic [7:0] data; logic [2:0] stat; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[5];

    int   total = 0;
    int   bad   = 0;
    int   last_done_cyc = 0;
    logic have_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int idx, input logic rd, input logic [6:0] chip,
                             input logic [7:0] ra, input logic [7:0] wd);
        req_read[idx]           = rd;
        req_chip_addr[7*idx +: 7] = chip;
        req_reg_addr[8*idx +: 8]  = ra;
        req_wdata[8*idx +: 8]     = wd;
        req_valid[idx]          = 1'b1;
    endtask

    // Poll at negedge+1 until cond-signal set; returns cycles waited.
    task automatic wait_ack(output int n);
        n = 0;
        #1;
        while (req_ack == '0 && n < 300) begin @(negedge clk); #1; n++; end
    endtask

    task automatic wait_en(output int n);
        n = 1;
        @(negedge clk); #1;
        while (!(m_write_en || m_read_en) && n < 300) begin @(negedge clk); #1; n++; end
    endtask

    task automatic wait_mdone();
        int n = 0;
        while (!m_done && n < 300) begin @(negedge clk); #1; n++; end
        chk("m_done_seen", {31'd0, m_done}, 32'd1);
    endtask

    // One complete transaction from the table; scoreboard checks command and response.
    task automatic run_vec(input vec_t v, input logic check_lat);
        int   n;
        int   lat;
        cmd_t c;
        rsp_t r;
        model_rdata  = v.mdata;
        model_status = v.mstat;
        cmd_q.push_back('{rd: v.rd, chip: v.chip, ra: v.ra, wd: v.wd});
        rsp_q.push_back('{done: v.exp_done, data: v.exp_data, stat: v.exp_stat});
        @(negedge clk);
        drive_req(v.idx, v.rd, v.chip, v.ra, v.wd);
        wait_ack(n);
        chk("ack", {30'd0, req_ack}, 32'(1 << v.idx));
        @(negedge clk);
        req_valid[v.idx] = 1'b0;
        #1;
        lat = 1;
        while (!(m_write_en || m_read_en) && lat < 300) begin @(negedge clk); #1; lat++; end
        if (check_lat) chk("en_latency", lat, 2);
        if (have_prev) begin
            chk("gap_min", {31'd0, (cyc - last_done_cyc - 1) >= GAP}, 32'd1);
            chk("gap_max", {31'd0, (cyc - last_done_cyc - 1) <= GAP + 3}, 32'd1);
        end
        c = cmd_q.pop_front();
        chk("read_en", {31'd0, m_read_en}, {31'd0, c.rd});
        chk("write_en", {31'd0, m_write_en}, {31'd0, !c.rd});
        chk("chip_addr", {25'd0, m_chip_addr}, {25'd0, c.chip});
        chk("reg_addr", {24'd0, m_reg_addr}, {24'd0, c.ra});
        chk("data_in", {24'd0, m_data_in}, {24'd0, c.wd});
        wait_mdone();
        last_done_cyc = cyc;
        have_prev = 1'b1;
        chk("done_not_early", {30'd0, req_done}, 32'd0);
        @(negedge clk); #1;
        r = rsp_q.pop_front();
        chk("req_done", {30'd0, req_done}, {30'd0, r.done});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, r.data});
        chk("rsp_status", {29'd0, rsp_status}, {29'd0, r.stat});
        $display("txn req=%0d rd=%0d chip=%h reg=%h done=%b data=%h status=%h",
                 v.idx, v.rd, m_chip_addr, m_reg_addr, req_done, rsp_data, rsp_status);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g[4];
        int         n;

        vecs[0] = '{0, 1'b0, 7'h72, 8'h41, 8'h00, 8'h00, 3'b000, 2'b01, 8'h00, 3'b000};
        vecs[1] = '{1, 1'b1, 7'h42, 8'h0A, 8'h00, 8'h76, 3'b000, 2'b10, 8'h76, 3'b000};
        vecs[2] = '{0, 1'b1, 7'h39, 8'hFF, 8'h11, 8'hA5, 3'b001, 2'b01, 8'hA5, 3'b001};
        vecs[3] = '{1, 1'b0, 7'h7F, 8'h00, 8'hFF, 8'h5A, 3'b100, 2'b10, 8'h5A, 3'b100};
        vecs[4] = '{1, 1'b1, 7'h20, 8'h33, 8'h00, 8'h3C, 3'b101, 2'b10, 8'h3C, 3'b101};

        reset = 1'b0; req_valid = '0; req_read = '0;
        req_chip_addr = '0; req_reg_addr = '0; req_wdata = '0;
        #1;
        chk("reset_outputs", {req_ack, req_done, rsp_data, rsp_status, m_chip_addr,
                              m_reg_addr, m_data_in, m_write_en, m_read_en}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Table: single writes and reads from each requester.
        for (int i = 0; i < 4; i++) run_vec(vecs[i], i == 0);

        // Contention: both held, expect alternating grants starting at 0.
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        have_prev = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b0, 7'h10, 8'h01, 8'h55);
        drive_req(1, 1'b0, 7'h11, 8'h02, 8'h66);
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            chk("cont_ack", {30'd0, req_ack}, {30'd0, exp_g[k]});
            @(negedge clk);
            if (k == 3) req_valid = '0;
            #1;
            n = 0;
            while (req_done == '0 && n < 300) begin @(negedge clk); #1; n++; end
            chk("cont_done", {30'd0, req_done}, {30'd0, exp_g[k]});
            $display("txn contention k=%0d done=%b", k, req_done);
        end

        // Timeout: master never answers.
        model_hang = 1'b1;
        @(negedge clk);
        drive_req(0, 1'b0, 7'h50, 8'h60, 8'h70);
        wait_ack(n);
        chk("to_ack", {30'd0, req_ack}, 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        n = 1;
        while (!(m_write_en || m_read_en) && n < 300) begin @(negedge clk); #1; n++; end
        chk("to_en", {31'd0, m_write_en}, 32'd1);
        n = 0;
        while (req_done == '0 && n < 300) begin @(negedge clk); #1; n++; end
        chk("to_latency", n, TO);
        chk("to_done", {30'd0, req_done}, 32'd1);
        chk("to_status", {29'd0, rsp_status}, 32'd7);
        chk("to_data", {24'd0, rsp_data}, 32'd0);
        $display("txn timeout req=0 done=%b status=%h after %0d cycles", req_done, rsp_status, n);
        model_hang = 1'b0;
        run_vec(vecs[4], 1'b0);

        // Reset while waiting on the master.
        model_lat = 30;
        @(negedge clk);
        drive_req(1, 1'b1, 7'h44, 8'h55, 8'h00);
        wait_ack(n);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_en(n);
        chk("rst_en", {31'd0, m_read_en}, 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {req_ack, req_done, rsp_data, rsp_status, m_chip_addr,
                                 m_reg_addr, m_data_in, m_write_en, m_read_en}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (req_done != '0) n++;
        end
        chk("no_done_after_reset", n, 0);
        $display("txn reset-in-wait stray_done=%0d", n);
        model_lat = 4;
        have_prev = 1'b0;
        run_vec(vecs[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
